// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the 8x16 register file write port, with pending-write scoreboard.
// Define RF_WB_ARB_RR_EN to swap the starvation escape for round-robin conflict arbitration.
module rf_wb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int STARVE_W     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [2:0]  req0_reg,
   input  logic [15:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [2:0]  req1_reg,
   input  logic [15:0] req1_data,
   output logic        req1_ready,
   input  logic        busy_set_valid,
   input  logic [2:0]  busy_set_reg,
   output logic [7:0]  busy,
   output logic        rf_write,
   output logic [2:0]  rf_writeregsel,
   output logic [15:0] rf_writedata,
   output logic        err
);

   logic        grant0_s;
   logic        grant1_s;
   logic        xfer_s;
   logic [2:0]  win_reg_s;
   logic [15:0] win_data_s;
   logic [7:0]  clr_mask_s;
   logic [7:0]  set_mask_s;
   logic [7:0]  busy_next_s;
   logic        err_set_s;

   logic [7:0]  busy_r;
   logic        err_r;
   logic        rf_write_r;
   logic [2:0]  rf_writeregsel_r;
   logic [15:0] rf_writedata_r;

`ifdef RF_WB_ARB_RR_EN
   logic        rr_ptr_r;
`else
   localparam logic [STARVE_W-1:0] STARVE_LIMIT_C = STARVE_W'(STARVE_LIMIT);
   logic [STARVE_W-1:0] starve_cnt_r;
`endif

   // Grant selection and winning write payload
   always_comb begin
      grant1_s   = 1'b0;
      grant0_s   = 1'b0;
      win_reg_s  = 3'd0;
      win_data_s = 16'h0000;
`ifdef RF_WB_ARB_RR_EN
      grant1_s = req1_valid & (~req0_valid | rr_ptr_r);
`else
      grant1_s = req1_valid & (~req0_valid | (starve_cnt_r == STARVE_LIMIT_C));
`endif
      grant0_s = req0_valid & ~grant1_s;
      xfer_s   = grant0_s | grant1_s;
      if (grant1_s) begin
         win_reg_s  = req1_reg;
         win_data_s = req1_data;
      end else begin
         win_reg_s  = req0_reg;
         win_data_s = req0_data;
      end
   end

   // Scoreboard next state; a set to the register being cleared re-marks it for the new producer
   always_comb begin
      clr_mask_s = 8'h00;
      set_mask_s = 8'h00;
      if (xfer_s) begin
         clr_mask_s = 8'h01 << win_reg_s;
      end else begin
         clr_mask_s = 8'h00;
      end
      if (busy_set_valid) begin
         set_mask_s = 8'h01 << busy_set_reg;
      end else begin
         set_mask_s = 8'h00;
      end
      busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
      err_set_s   = (|(set_mask_s & busy_r & ~clr_mask_s)) | (|(clr_mask_s & ~busy_r));
   end

   // Output stage, scoreboard and sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_write_r       <= 1'b0;
         rf_writeregsel_r <= 3'd0;
         rf_writedata_r   <= 16'h0000;
         busy_r           <= 8'h00;
         err_r            <= 1'b0;
      end else begin
         rf_write_r <= xfer_s;
         if (xfer_s) begin
            rf_writeregsel_r <= win_reg_s;
            rf_writedata_r   <= win_data_s;
         end else begin
            rf_writeregsel_r <= rf_writeregsel_r;
            rf_writedata_r   <= rf_writedata_r;
         end
         busy_r <= busy_next_s;
         err_r  <= err_r | err_set_s;
      end
   end

`ifdef RF_WB_ARB_RR_EN
   // Round-robin pointer flips after every conflicted transfer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_r <= 1'b0;
      end else if (req0_valid & req1_valid) begin
         rr_ptr_r <= ~rr_ptr_r;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end
`else
   // Count consecutive cycles port 1 waits; reaching the limit forces its grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_r <= '0;
      end else if (req1_valid & ~grant1_s) begin
         if (starve_cnt_r != STARVE_LIMIT_C) begin
            starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= '0;
      end
   end
`endif

   assign req0_ready     = grant0_s;
   assign req1_ready     = grant1_s;
   assign busy           = busy_r;
   assign err            = err_r;
   assign rf_write       = rf_write_r;
   assign rf_writeregsel = rf_writeregsel_r;
   assign rf_writedata   = rf_writedata_r;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 8x16 register file (rf) between two writeback requesters.
  - Port 0: the single-cycle ALU path.
  - Port 1: the multicycle/load path.
- Registers the winning write onto rf's write/writeregsel/writedata inputs.
- Keeps an 8-bit pending-write scoreboard so issue logic can stall on registers whose results are still outstanding.
- Sits between the execute/memory stages and rf.

Parameters:
STARVE_LIMIT, 4, consecutive lost cycles after which port 1 wins over port 0 (range 1..7)
STARVE_W, 3, width of the starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
req0_valid  in  1  port 0 has a write pending
req0_reg  in  3  port 0 destination register
req0_data  in  16  port 0 write data
req0_ready  out  1  port 0 write accepted this cycle
req1_valid  in  1  port 1 has a write pending
req1_reg  in  3  port 1 destination register
req1_data  in  16  port 1 write data
req1_ready  out  1  port 1 write accepted this cycle
busy_set_valid  in  1  issue stage marks a register as pending
busy_set_reg  in  3  register to mark pending
busy  out  8  pending-write scoreboard, bit n = register n
rf_write  out  1  to rf write
rf_writeregsel  out  3  to rf writeregsel
rf_writedata  out  16  to rf writedata
err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, asynchronous), all of the following cleared; reset mid-transfer discards the in-flight write with no rf write:
  - rf_write=0, rf_writeregsel=0, rf_writedata=0
  - busy=8'h00, err=0, starve_cnt=0
  - req0_ready and req1_ready evaluate to 0 while no valid is asserted.
- Grant (combinational, same cycle as valid):
  - grant1 = req1_valid & (!req0_valid | starve_cnt==STARVE_LIMIT)
  - grant0 = req0_valid & !grant1
  - reqN_ready = grantN. A transfer occurs when valid & ready.
  - Requesters hold valid, reg and data stable until ready.
- Starvation counter:
  - Increments on each cycle with req1_valid & !req1_ready, saturating at STARVE_LIMIT.
  - Clears on a port 1 transfer, or on a cycle with req1_valid=0.
- Output stage, fixed latency of 1 cycle from transfer to rf write:
  - On a transfer edge: rf_write<=1, rf_writeregsel<=reg of the winner, rf_writedata<=data of the winner.
  - Otherwise rf_write<=0, and regsel/data hold their values.
  - At most one rf write per cycle.
- Scoreboard, updated at the clock edge:
  - Transfer to register r clears busy[r].
  - busy_set_valid sets busy[busy_set_reg].
  - Same register set and cleared in the same cycle: set wins (new producer).
- err (sticky until reset) is set by either condition:
  - busy_set to a register already busy and not cleared that cycle.
  - Transfer to a register whose busy bit is 0.
- Both ports valid to the same register: only the winner writes; the loser stays pending and writes later (last writer wins in rf).
- No combinational path from rf outputs back into the arbiter.

Optional Feature:
- Macro: RF_WB_ARB_RR_EN.
- Defined:
  - Starvation counter removed.
  - Replaced by a 1-bit round-robin pointer, reset to port 0.
  - On a conflict (both valid) the pointer's port wins; the pointer flips to the other port after each conflicted transfer.
  - A lone valid is always granted and leaves the pointer unchanged.
- Undefined: fixed priority to port 0 plus STARVE_LIMIT starvation escape, as described above.

Test Plan:
- Reset sequence:
  - Stimulus: drive rst=0 mid-operation with a transfer pending, then rst=1.
  - Required: busy=00, rf_write=0, err=0 immediately; no rf write occurs for the pending transfer.
- Single request:
  - Stimulus: busy_set r3; then req0 r3 with data 16'hBEEF.
  - Required: req0_ready same cycle; next cycle rf_write=1, rf_writeregsel=3, rf_writedata=BEEF; busy[3]=0 after the transfer edge.
- Starvation escape:
  - Stimulus: req0 and req1 both held valid, STARVE_LIMIT=4.
  - Required: port 0 wins 4 cycles; port 1 wins on the 5th; counter clears.
  - Required: in RF_WB_ARB_RR_EN builds, grants alternate 0,1,0,1.
- Set/clear collision:
  - Stimulus: a port 1 transfer to r5 and busy_set r5 in the same cycle.
  - Required: busy[5]=1 afterwards; err=0.
- Error detection:
  - Stimulus: busy_set r2 twice with no write in between.
  - Required: err=1 and stays 1 until rst=0.
  - Stimulus: a transfer to a non-busy register.
  - Required: err=1.
- Back-to-back transfers:
  - Stimulus: req0 writes r1=0001, r2=0002, r3=0003 on consecutive cycles.
  - Required: rf writes on three consecutive cycles in order; read-back through rf matches.
